repeat_seq_ctrl: RTL and testbench
==================================

# repeat_seq_ctrl

Controller that sequences a hold-and-step count generator: it produces values 0,1,…,LAST and holds each value for REP accepted beats, e.g. 0,0,0,1,1,1,2,2,2 for REP=3, LAST=2. Software-style start/busy/done handshake on the control side and a valid/ready stream on the output side let one generator be programmed per run and throttled by a downstream consumer. It sits between a run scheduler and any datapath that consumes repeated index patterns, such as address or tap sequencers.

## Interface
Parameters:
- VW, 4, width of the output value and of `last_cfg`.
- RW, 4, width of the repeat count `rep_cfg`.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new run; sampled only in IDLE or DONE.
- abort  in  1  terminate the current run.
- rep_cfg  in  RW  beats per value; 0 is treated as 1.
- last_cfg  in  VW  final value of the run.
- out_ready  in  1  consumer accepts the current value.
- cnt  out  VW  current value, registered.
- out_valid  out  1  `cnt` is valid; high only in RUN.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the final beat.
- loop  in  1  present only with `REPEAT_WRAP_EN`.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset enters IDLE.
- Reset values: `cnt`=0, internal hold count `icnt`=1, `out_valid`=0, `busy`=0, `done`=0.
- **IDLE/DONE to RUN** on `start`=1 with `abort`=0:
  - Latch `rep_l` = max(`rep_cfg`,1) and `last_l` = `last_cfg`.
  - Set `cnt`=0 and `icnt`=1.
  - `rep_cfg` and `last_cfg` are ignored at all other times.
- **Beat** = `out_valid` & `out_ready` in RUN. A cycle without a beat holds `cnt` and `icnt` unchanged.
- **On a beat:**
  - If `icnt`≠`rep_l`, increment `icnt`.
  - Otherwise set `icnt`=1, and then:
    - if `cnt`≠`last_l`, increment `cnt`;
    - else this is the final beat: go to DONE and set `cnt`=0.
- **DONE** lasts exactly one cycle with `done`=1, then returns to IDLE. A `start` in DONE goes directly to RUN.
- **abort in RUN** takes effect next cycle:
  - IDLE, `cnt`=0, `icnt`=1.
  - No `done` pulse.
  - Abort overrides a coincident final beat.
- `abort` in IDLE or DONE cancels a coincident `start`.
- `start` in RUN is ignored.
- Arithmetic rules:
  - `icnt` is RW+1 bits wide, so `rep_l` = 2^RW−1 never overflows.
  - `cnt` never exceeds `last_l`, so there is no modular wrap.
  - `last_cfg` = 2^VW−1 is legal.
- A run delivers exactly (`last_l`+1)·`rep_l` beats.

## Timing
- `start` sampled at edge T: `out_valid`=1, `busy`=1, `cnt`=0 from T+1.
- One value step per beat. Zero added latency under continuous `out_ready`.
- Final beat at edge N:
  - At N+1: `done`=1, `busy`=0, `out_valid`=0.
  - At N+2: `done`=0.
- Back-to-back runs: `start` during DONE puts the next run's first value at N+2.
- All outputs are registered. No combinational path from `out_ready` to any output.
- `rst` mid-run returns every output to its reset value at the next edge, overriding all other inputs.

## Configuration
`REPEAT_WRAP_EN`:
- **Defined:**
  - The `loop` port exists and is sampled on the final beat.
  - If `loop`=1, the run wraps: `cnt`=0, `icnt`=1, the block stays in RUN and no `done` is issued.
  - If `loop`=0, the run ends normally.
  - `abort` remains the only exit from a looping run.
- **Undefined:**
  - The `loop` port is absent.
  - Every run terminates after (`last_l`+1)·`rep_l` beats with a `done` pulse.

## Test plan
- REP=5, LAST=5, `out_ready`=1:
  - `cnt` = 0×5, 1×5, …, 5×5 (30 beats).
  - `done` pulse one cycle after beat 30; `busy` falls in the same cycle as `done`.
- REP=0, LAST=3: behaves as REP=1. `cnt` = 0,1,2,3, then `done`.
- REP=2, LAST=1, `out_ready` toggling 1,0,0,1,…:
  - `cnt` and `out_valid` hold through the stalls.
  - Exactly 4 beats are accepted (0,0,1,1), then `done`.
- `abort` at beat 7 of a REP=3, LAST=4 run:
  - Next cycle: IDLE, `cnt`=0, `out_valid`=0, no `done`.
  - `rst` asserted mid-run gives the same outputs.
- `start` asserted during the `done` cycle with new config REP=1, LAST=2: the second run emits 0,1,2 starting two cycles after the previous final beat.
- `REPEAT_WRAP_EN` with `loop`=1, REP=2, LAST=1: `cnt` = 0,0,1,1,0,0,1,1,… with no `done`. Dropping `loop` before a final beat ends the run with `done`.

Source files
------------

// File: rtl/repeat_seq_ctrl.sv
// rtl/repeat_seq_ctrl.sv - hold-and-step count generator with start/busy/done control and valid/ready output
// Optional REPEAT_WRAP_EN adds a loop input that restarts the sequence instead of finishing.
module repeat_seq_ctrl #(
  parameter int VW = 4,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [RW-1:0] rep_cfg,
  input  logic [VW-1:0] last_cfg,
  input  logic          out_ready,
`ifdef REPEAT_WRAP_EN
  input  logic          loop,
`endif
  output logic [VW-1:0] cnt,
  output logic          out_valid,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [VW-1:0] V_ONE = VW'(1);
  localparam logic [RW:0]   R_ONE = (RW+1)'(1);

  state_t        state_q, state_d;
  logic [VW-1:0] cnt_q, cnt_d;
  logic [VW-1:0] last_q, last_d;
  // One extra bit so a hold count of 2^RW-1 compares cleanly without wrap.
  logic [RW:0]   icnt_q, icnt_d;
  logic [RW:0]   rep_q, rep_d;
  logic          busy_q, done_q;
  logic          beat;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    icnt_d  = icnt_q;
    rep_d   = rep_q;
    last_d  = last_q;
    beat    = (state_q == S_RUN) && out_ready;
    case (state_q)
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          icnt_d  = R_ONE;
        end else if (beat) begin
          if (icnt_q != rep_q) begin
            icnt_d = icnt_q + R_ONE;
          end else begin
            icnt_d = R_ONE;
            if (cnt_q != last_q) begin
              cnt_d = cnt_q + V_ONE;
            end else begin
              cnt_d = '0;
`ifdef REPEAT_WRAP_EN
              if (!loop) state_d = S_DONE;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start && !abort) begin
          state_d = S_RUN;
          rep_d   = (rep_cfg == '0) ? R_ONE : {1'b0, rep_cfg};
          last_d  = last_cfg;
          cnt_d   = '0;
          icnt_d  = R_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      icnt_q  <= R_ONE;
      rep_q   <= R_ONE;
      last_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      icnt_q  <= icnt_d;
      rep_q   <= rep_d;
      last_q  <= last_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign cnt       = cnt_q;
  assign out_valid = busy_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_repeat_seq_ctrl.sv
// tb/tb_repeat_seq_ctrl.sv - directed self-checking bench for repeat_seq_ctrl
// Status vector compared each cycle is {out_valid, busy, done, cnt}.
module tb_repeat_seq_ctrl;
  localparam int VW = 4;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [RW-1:0] rep_cfg = '0;
  logic [VW-1:0] last_cfg = '0;
  logic          out_ready = 1'b0;
`ifdef REPEAT_WRAP_EN
  logic          loop = 1'b0;
`endif
  logic [VW-1:0] cnt;
  logic          out_valid, busy, done;

  int n_checks = 0;
  int n_fail = 0;

  repeat_seq_ctrl #(.VW(VW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rep_cfg(rep_cfg), .last_cfg(last_cfg), .out_ready(out_ready),
`ifdef REPEAT_WRAP_EN
    .loop(loop),
`endif
    .cnt(cnt), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW+2:0] stat(input logic v, input logic b, input logic d, input int c);
    return {v, b, d, VW'(c)};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({out_valid, busy, done, cnt} !== stat(0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset: got %b required %b", {out_valid, busy, done, cnt}, stat(0, 0, 0, 0));
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_run(input int rep, input int last, input string name);
    int re;
    int total;
    re = (rep == 0) ? 1 : rep;
    total = (last + 1) * re;
    rep_cfg = RW'(rep);
    last_cfg = VW'(last);
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    rep_cfg = RW'(rep + 3);
    last_cfg = VW'(last + 7);
    for (int k = 0; k < total; k++) begin
      n_checks++;
      if ({out_valid, busy, done, cnt} !== stat(1, 1, 0, k / re)) begin
        n_fail++;
        $display("FAIL %s beat %0d: got %b required %b", name, k, {out_valid, busy, done, cnt}, stat(1, 1, 0, k / re));
      end
      step();
    end
    n_checks++;
    if ({out_valid, busy, done, cnt} !== stat(0, 0, 1, 0)) begin
      n_fail++;
      $display("FAIL %s done: got %b required %b", name, {out_valid, busy, done, cnt}, stat(0, 0, 1, 0));
    end
    step();
    n_checks++;
    if ({out_valid, busy, done, cnt} !== stat(0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL %s idle: got %b required %b", name, {out_valid, busy, done, cnt}, stat(0, 0, 0, 0));
    end
  endtask

  task automatic test_stall();
    int beats;
    int cyc;
    beats = 0;
    cyc = 0;
    rep_cfg = 4'd2;
    last_cfg = 4'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    while (beats < 4 && cyc < 40) begin
      out_ready = (cyc % 3 == 0);
      n_checks++;
      if ({out_valid, busy, done, cnt} !== stat(1, 1, 0, beats / 2)) begin
        n_fail++;
        $display("FAIL stall cycle %0d: got %b required %b", cyc, {out_valid, busy, done, cnt}, stat(1, 1, 0, beats / 2));
      end
      step();
      if (out_ready) beats++;
      cyc++;
    end
    out_ready = 1'b0;
    n_checks++;
    if (beats != 4 || {out_valid, busy, done, cnt} !== stat(0, 0, 1, 0)) begin
      n_fail++;
      $display("FAIL stall done: beats %0d got %b required 4 beats and %b", beats, {out_valid, busy, done, cnt}, stat(0, 0, 1, 0));
    end
    step();
  endtask

  task automatic test_abort();
    rep_cfg = 4'd3;
    last_cfg = 4'd4;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    n_checks++;
    if ({out_valid, busy, done, cnt} !== stat(1, 1, 0, 2)) begin
      n_fail++;
      $display("FAIL abort pre: got %b required %b", {out_valid, busy, done, cnt}, stat(1, 1, 0, 2));
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if ({out_valid, busy, done, cnt} !== stat(0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL abort: got %b required %b", {out_valid, busy, done, cnt}, stat(0, 0, 0, 0));
    end
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort no done: got done=%b busy=%b required 0 0", done, busy);
    end
    // abort coinciding with the only (final) beat must suppress done
    rep_cfg = 4'd1;
    last_cfg = 4'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if ({out_valid, busy, done, cnt} !== stat(0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL abort final beat: got %b required %b", {out_valid, busy, done, cnt}, stat(0, 0, 0, 0));
    end
    // abort in IDLE cancels a coincident start
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    n_checks++;
    if ({out_valid, busy, done, cnt} !== stat(0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL abort cancels start: got %b required %b", {out_valid, busy, done, cnt}, stat(0, 0, 0, 0));
    end
  endtask

  task automatic test_rst_mid();
    rep_cfg = 4'd3;
    last_cfg = 4'd4;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    n_checks++;
    if ({out_valid, busy, done, cnt} !== stat(0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL rst mid-run: got %b required %b", {out_valid, busy, done, cnt}, stat(0, 0, 0, 0));
    end
    step();
  endtask

  task automatic test_back_to_back();
    int exp_q[$];
    exp_q = '{0, 0, 1, 1};
    rep_cfg = 4'd2;
    last_cfg = 4'd1;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    // start stays high through the first run: ignored in RUN, honoured in DONE
    rep_cfg = 4'd1;
    last_cfg = 4'd2;
    foreach (exp_q[k]) begin
      n_checks++;
      if ({out_valid, busy, done, cnt} !== stat(1, 1, 0, exp_q[k])) begin
        n_fail++;
        $display("FAIL b2b run1 beat %0d: got %b required %b", k, {out_valid, busy, done, cnt}, stat(1, 1, 0, exp_q[k]));
      end
      step();
    end
    n_checks++;
    if ({out_valid, busy, done, cnt} !== stat(0, 0, 1, 0)) begin
      n_fail++;
      $display("FAIL b2b done: got %b required %b", {out_valid, busy, done, cnt}, stat(0, 0, 1, 0));
    end
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({out_valid, busy, done, cnt} !== stat(1, 1, 0, k)) begin
        n_fail++;
        $display("FAIL b2b run2 beat %0d: got %b required %b", k, {out_valid, busy, done, cnt}, stat(1, 1, 0, k));
      end
      step();
    end
    n_checks++;
    if ({out_valid, busy, done, cnt} !== stat(0, 0, 1, 0)) begin
      n_fail++;
      $display("FAIL b2b run2 done: got %b required %b", {out_valid, busy, done, cnt}, stat(0, 0, 1, 0));
    end
    step();
  endtask

`ifdef REPEAT_WRAP_EN
  task automatic test_wrap();
    rep_cfg = 4'd2;
    last_cfg = 4'd1;
    out_ready = 1'b1;
    loop = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if ({out_valid, busy, done, cnt} !== stat(1, 1, 0, (k / 2) % 2)) begin
        n_fail++;
        $display("FAIL wrap beat %0d: got %b required %b", k, {out_valid, busy, done, cnt}, stat(1, 1, 0, (k / 2) % 2));
      end
      step();
    end
    loop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({out_valid, busy, done, cnt} !== stat(1, 1, 0, k / 2)) begin
        n_fail++;
        $display("FAIL wrap exit beat %0d: got %b required %b", k, {out_valid, busy, done, cnt}, stat(1, 1, 0, k / 2));
      end
      step();
    end
    n_checks++;
    if ({out_valid, busy, done, cnt} !== stat(0, 0, 1, 0)) begin
      n_fail++;
      $display("FAIL wrap exit done: got %b required %b", {out_valid, busy, done, cnt}, stat(0, 0, 1, 0));
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_full_run(5, 5, "rep5_last5");
    test_full_run(0, 3, "rep0_last3");
    test_full_run(15, 15, "rep15_last15");
    test_stall();
    test_abort();
    test_rst_mid();
    test_back_to_back();
`ifdef REPEAT_WRAP_EN
    test_wrap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
